// File: rtl/gf_horner_eval.sv
// gf_horner_eval: Horner-rule evaluator of g(x) over GF(2^16) at alpha.
// Reads coefficients g_t..g_0 from a synchronous coefficient memory and
// feeds one Horner step per clock into an external registered
// multiply-add unit (C = A*B + ADD, one-cycle latency).
// Optional feature macro: HORNER_ZERO_FLAG_EN adds the is_root output.
//
// state | meaning
// IDLE  | waiting for start; accepting start issues read of g_t
// FETCH | first step: 0*alpha + g_t; issue read of g_{t-1} if t>0
// ITER  | step acc*alpha + g_i; issue next lower read while one remains
// DRAIN | acc_t on mul_c, capture into result
// DONE  | one-cycle done pulse
module gf_horner_eval #(
   parameter int M     = 16,
   parameter int DEG_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DEG_W-1:0] degree,
   input  logic [0:M-1]     alpha,
   output logic             coef_rd_en,
   output logic [DEG_W-1:0] coef_addr,
   input  logic [0:M-1]     coef_data,
   output logic [0:M-1]     mul_a,
   output logic [0:M-1]     mul_b,
   output logic [0:M-1]     mul_add,
   input  logic [0:M-1]     mul_c,
   output logic             busy,
   output logic             done,
   output logic [0:M-1]     result
`ifdef HORNER_ZERO_FLAG_EN
   ,
   output logic             is_root
`endif
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_ITER  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [DEG_W-1:0] r_addr;
   logic [0:M-1]     r_alpha;
   logic [0:M-1]     r_result;
   logic             w_accept;
   logic             w_addr_zero;

   // start is dropped when reset is asserted in the same cycle
   assign w_accept    = (r_state == S_IDLE) && start && !rst;
   // r_addr holds the index of the coefficient arriving this cycle, so it
   // doubles as the down-counter whose terminal count ends the iteration
   assign w_addr_zero = (r_addr == '0);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_next = S_FETCH;
         S_FETCH: w_state_next = w_addr_zero ? S_DRAIN : S_ITER;
         S_ITER:  if (w_addr_zero) w_state_next = S_DRAIN;
         S_DRAIN: w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Output logic: memory reads, multiply-add operands, status
   always_comb begin
      coef_rd_en = 1'b0;
      coef_addr  = r_addr;
      mul_a      = '0;
      mul_b      = '0;
      mul_add    = '0;
      busy       = (r_state != S_IDLE);
      done       = (r_state == S_DONE);
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               coef_rd_en = 1'b1;
               coef_addr  = degree;
            end
         end
         S_FETCH: begin
            mul_b   = r_alpha;
            mul_add = coef_data;
            if (!w_addr_zero) begin
               coef_rd_en = 1'b1;
               coef_addr  = r_addr - DEG_W'(1);
            end
         end
         S_ITER: begin
            mul_a   = mul_c;
            mul_b   = r_alpha;
            mul_add = coef_data;
            if (!w_addr_zero) begin
               coef_rd_en = 1'b1;
               coef_addr  = r_addr - DEG_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Datapath registers: last issued address, latched alpha, result
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr   <= '0;
         r_alpha  <= '0;
         r_result <= '0;
      end else begin
         r_addr <= coef_addr;
         if (w_accept) r_alpha <= alpha;
         if (r_state == S_DRAIN) r_result <= mul_c;
      end
   end

   assign result = r_result;

`ifdef HORNER_ZERO_FLAG_EN
   logic r_is_root;

   // Zero flag captured alongside the result
   always_ff @(posedge clk) begin
      if (rst) begin
         r_is_root <= 1'b0;
      end else if (r_state == S_DRAIN) begin
         r_is_root <= (mul_c == '0);
      end
   end

   assign is_root = r_is_root;
`endif

endmodule
